// File: rtl/renode_axi_pkg.sv
// Shared AXI4 types for the renode AXI blocks: burst fields, response codes,
// manager FSM states and the 4 KiB boundary helper.
package renode_axi_pkg;

  typedef logic [2:0] burst_size_t;
  typedef logic [7:0] burst_length_t;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } response_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } axi_mgr_state_e;

  // True when an INCR burst starting at byte offset addr_lo runs past the 4 KiB page end.
  function automatic logic crosses_4k(input logic [11:0]   addr_lo,
                                      input burst_length_t len,
                                      input burst_size_t   size);
    logic [16:0] bytes;
    bytes = (17'(len) + 17'd1) << size;
    return (17'(addr_lo) + bytes) > 17'd4096;
  endfunction

endpackage

// File: rtl/axi_burst_manager.sv
// Single-outstanding AXI4 manager: turns one local command into one INCR burst,
// streams write/read beats straight through and reports a completion.
module axi_burst_manager
  import renode_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [2:0]              cmd_size,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [1:0]              rd_resp,
  output logic                    rd_last,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [1:0]              done_resp,
  output logic                    done_err,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  axi_mgr_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  burst_length_t           len_q, len_d;
  burst_size_t             size_q, size_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  burst_length_t           beat_cnt_q, beat_cnt_d;
  response_e               resp_acc_q, resp_acc_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   align_mask;
  logic                    cmd_bad;
  logic                    last_beat;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

  assign align_mask = ~({ADDR_WIDTH{1'b1}} << cmd_size);
  assign cmd_bad    = (cmd_size > burst_size_t'(MAX_SIZE)) ||
                      ((cmd_addr & align_mask) != '0) ||
                      crosses_4k(cmd_addr[11:0], cmd_len, cmd_size);
  assign last_beat  = (beat_cnt_q == len_q);

  // cmd_ready is held low while reset is asserted even though the state is already IDLE
  assign cmd_ready  = (state_q == S_IDLE) && !areset;

  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = BURST_INCR;
  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = BURST_INCR;

  assign wdata   = wr_data;
  assign wstrb   = wr_strb;
  assign wlast   = last_beat;
  assign rd_data = rdata;
  assign rd_resp = rresp;
  assign rd_last = rlast;

  assign done_resp = resp_acc_q;
  assign done_err  = err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      resp_acc_q <= OKAY;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      resp_acc_q <= resp_acc_d;
      err_q      <= err_d;
    end
    addr_q <= addr_d;
    len_q  <= len_d;
    size_q <= size_d;
    id_q   <= id_d;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    id_d       = id_q;
    beat_cnt_d = beat_cnt_q;
    resp_acc_d = resp_acc_q;
    err_d      = err_q;
    awvalid    = 1'b0;
    arvalid    = 1'b0;
    wvalid     = 1'b0;
    wr_ready   = 1'b0;
    bready     = 1'b0;
    rready     = 1'b0;
    rd_valid   = 1'b0;
    done_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          size_d = cmd_size;
          id_d   = cmd_id;
          if (cmd_bad) begin
            state_d    = S_DONE;
            resp_acc_d = SLVERR;
            err_d      = 1'b1;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
        end
      end
      S_AW: begin
        awvalid = 1'b1;
        if (awready) state_d = S_W;
      end
      S_W: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        if (wr_valid && wready) begin
          if (last_beat) begin
            state_d    = S_B;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          resp_acc_d = response_e'(resp_max(resp_acc_q, bresp));
          if (bid != id_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rd_valid = rvalid;
        rready   = rd_ready;
        if (rvalid && rd_ready) begin
          resp_acc_d = response_e'(resp_max(resp_acc_q, rresp));
          if ((rlast != last_beat) || (rid != id_q)) err_d = 1'b1;
          // A missing or early rlast still ends the burst; the mismatch is flagged above
          if (last_beat || rlast) begin
            state_d    = S_DONE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_d    = S_IDLE;
          beat_cnt_d = '0;
          resp_acc_d = OKAY;
          err_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_manager.sv
// Bench for axi_burst_manager: a cycle-stepped subordinate/source model with
// scoreboard queues for write and read beats, driven from a command table.
module tb_axi_burst_manager;

  localparam int AWD = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AWD-1:0]  cmd_addr;
  logic [7:0]      cmd_len;
  logic [2:0]      cmd_size;
  logic [IW-1:0]   cmd_id;
  logic            wr_valid, wr_ready;
  logic [DW-1:0]   wr_data;
  logic [DW/8-1:0] wr_strb;
  logic            rd_valid, rd_ready;
  logic [DW-1:0]   rd_data;
  logic [1:0]      rd_resp;
  logic            rd_last;
  logic            done_valid, done_ready;
  logic [1:0]      done_resp;
  logic            done_err;
  logic [IW-1:0]   awid;
  logic [AWD-1:0]  awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [IW-1:0]   bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [IW-1:0]   arid;
  logic [AWD-1:0]  araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_burst_manager #(.ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_id(cmd_id),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
    .rd_last(rd_last),
    .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp),
    .done_err(done_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  typedef struct {
    bit         w;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          early;
    bit          badid;
    bit          stall;
    logic [1:0]  exp_resp;
    bit          exp_err;
    int          exp_beats;
    bit          exp_bus;
  } vec_t;

  localparam int NV = 12;
  vec_t tv[NV];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [72:0] wq[$];
  logic [66:0] rq[$];

  bit          stall;
  int          early;
  logic [1:0]  rresp_cfg, bresp_cfg;
  bit          badid;
  logic [63:0] salt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic coin();
    return stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Runs one command to completion; called and returns on a negative clock edge.
  task automatic run_cmd(input bit w, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [3:0] id,
                         output logic [1:0] resp, output logic err,
                         output int nb, output bit bus);
    int wsent, rsent, cyc, acc_cyc;
    bit acc, fin, r_act, b_pend, w_hs, r_hs, b_hs, a_seen;
    logic [72:0] we;
    logic [66:0] re;
    wsent = 0; rsent = 0; cyc = 0; acc_cyc = -100;
    acc = 0; fin = 0; r_act = 0; b_pend = 0; w_hs = 0; r_hs = 0; b_hs = 0; a_seen = 0;
    resp = '0; err = 1'b0; nb = 0; bus = 0;
    wq.delete();
    rq.delete();
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_id = id;
    while (!fin && cyc < 4000) begin
      if (acc) cmd_valid = 1'b0;
      if (w_hs) wr_valid = 1'b0;
      if (b_hs) bvalid = 1'b0;
      if (r_hs) rvalid = 1'b0;
      w_hs = 0; r_hs = 0; b_hs = 0;
      awready = coin(); wready = coin(); arready = coin();
      rd_ready = coin(); done_ready = coin();
      if (acc && w && !wr_valid && wsent <= int'(l) && coin()) begin
        wr_valid = 1'b1;
        wr_data  = salt ^ 64'(wsent + 1);
        wr_strb  = 8'hFF ^ 8'(wsent);
        wq.push_back({wr_strb, 1'(wsent == int'(l)), wr_data});
        wsent++;
      end
      if (b_pend && !bvalid && coin()) begin
        bvalid = 1'b1; bresp = bresp_cfg; bid = badid ? (id ^ 4'd1) : id;
      end
      if (r_act && !rvalid && coin()) begin
        rvalid = 1'b1;
        rdata  = {$urandom, $urandom};
        rresp  = rresp_cfg;
        rlast  = (rsent == int'(l)) || (rsent == early);
        rid    = badid ? (id ^ 4'd1) : id;
        rq.push_back({rresp, rlast, rdata});
        if (rlast) r_act = 0;
        rsent++;
      end
      #1;
      if (cmd_valid && cmd_ready) begin acc = 1; acc_cyc = cyc; end
      if (awvalid || arvalid || wvalid) bus = 1;
      if ((awvalid || arvalid) && !a_seen) begin
        a_seen = 1;
        chk("a_valid_latency", 128'(cyc - acc_cyc), 128'(1));
      end
      if (awvalid && awready)
        chk("aw_fields", 128'({awid, awaddr, awlen, awsize, awburst}), 128'({id, a, l, s, 2'b01}));
      if (arvalid && arready) begin
        chk("ar_fields", 128'({arid, araddr, arlen, arsize, arburst}), 128'({id, a, l, s, 2'b01}));
        r_act = 1;
      end
      if ((wr_valid && wr_ready) || (wvalid && wready)) begin
        chk("w_handshake_match", 128'(wr_valid && wr_ready), 128'(wvalid && wready));
        w_hs = wr_valid && wr_ready;
        if (wq.size() == 0) chk("w_unexpected_beat", 128'(1), 128'(0));
        else begin
          we = wq.pop_front();
          chk("w_beat", 128'({wstrb, wlast, wdata}), 128'(we));
          if (we[64]) b_pend = 1;
        end
        nb++;
      end
      if (bvalid && bready) begin b_hs = 1; b_pend = 0; end
      if ((rd_valid && rd_ready) || (rvalid && rready)) begin
        chk("r_handshake_match", 128'(rd_valid && rd_ready), 128'(rvalid && rready));
        r_hs = rvalid && rready;
        if (rq.size() == 0) chk("r_unexpected_beat", 128'(1), 128'(0));
        else begin
          re = rq.pop_front();
          chk("rd_beat", 128'({rd_resp, rd_last, rd_data}), 128'(re));
        end
        nb++;
      end
      if (done_valid && done_ready) begin
        resp = done_resp; err = done_err; fin = 1;
      end
      @(posedge aclk);
      @(negedge aclk);
      cyc++;
    end
    if (!fin) chk("done_timeout", 128'(0), 128'(1));
    cmd_valid = 1'b0; wr_valid = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    rd_ready = 1'b0; done_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    logic       err;
    int         nb;
    bit         bus;

    areset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_id = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0; done_ready = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0; arready = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    stall = 0; early = -1; rresp_cfg = 0; bresp_cfg = 0; badid = 0; salt = '0;

    //         w  addr        len     size  id    rresp bresp early badid stall resp err beats bus
    tv[0]  = '{1, 32'h100,  8'd3,   3'd3, 4'h5, 2'd0, 2'd0, -1, 0, 0, 2'd0, 0, 4,   1};
    tv[1]  = '{0, 32'h2000, 8'd0,   3'd2, 4'h2, 2'd2, 2'd0, -1, 0, 0, 2'd2, 0, 1,   1};
    tv[2]  = '{1, 32'hFF8,  8'd1,   3'd3, 4'h1, 2'd0, 2'd0, -1, 0, 0, 2'd2, 1, 0,   0};
    tv[3]  = '{0, 32'h102,  8'd0,   3'd2, 4'h1, 2'd0, 2'd0, -1, 0, 0, 2'd2, 1, 0,   0};
    tv[4]  = '{0, 32'h400,  8'd7,   3'd3, 4'h7, 2'd0, 2'd0,  2, 0, 0, 2'd0, 1, 3,   1};
    tv[5]  = '{0, 32'h0,    8'd0,   3'd4, 4'h1, 2'd0, 2'd0, -1, 0, 0, 2'd2, 1, 0,   0};
    tv[6]  = '{1, 32'hFF0,  8'd1,   3'd3, 4'h9, 2'd0, 2'd1, -1, 0, 0, 2'd1, 0, 2,   1};
    tv[7]  = '{1, 32'h3000, 8'd255, 3'd3, 4'hA, 2'd0, 2'd0, -1, 0, 1, 2'd0, 0, 256, 1};
    tv[8]  = '{0, 32'h5800, 8'd255, 3'd3, 4'hB, 2'd1, 2'd0, -1, 0, 1, 2'd1, 0, 256, 1};
    tv[9]  = '{1, 32'h7,    8'd0,   3'd0, 4'hC, 2'd0, 2'd3, -1, 0, 0, 2'd3, 0, 1,   1};
    tv[10] = '{1, 32'h40,   8'd1,   3'd2, 4'h4, 2'd0, 2'd0, -1, 1, 0, 2'd0, 1, 2,   1};
    tv[11] = '{0, 32'h80,   8'd1,   3'd3, 4'h6, 2'd0, 2'd0, -1, 1, 1, 2'd0, 1, 2,   1};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    #1;
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_outputs", 128'({awvalid, wvalid, bready, arvalid, rready, done_valid, done_err, done_resp}),
        128'(0));
    areset = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 128'(cmd_ready), 128'(1));
    @(negedge aclk);

    for (int i = 0; i < NV; i++) begin
      stall = tv[i].stall; early = tv[i].early; badid = tv[i].badid;
      rresp_cfg = tv[i].rresp; bresp_cfg = tv[i].bresp;
      salt = (i == 0) ? 64'd0 : {$urandom, $urandom};
      run_cmd(tv[i].w, tv[i].addr, tv[i].len, tv[i].size, tv[i].id, resp, err, nb, bus);
      chk($sformatf("v%0d_done_resp", i), 128'(resp), 128'(tv[i].exp_resp));
      chk($sformatf("v%0d_done_err", i), 128'(err), 128'(tv[i].exp_err));
      chk($sformatf("v%0d_beats", i), 128'(nb), 128'(tv[i].exp_beats));
      chk($sformatf("v%0d_bus_activity", i), 128'(bus), 128'(tv[i].exp_bus));
      #1;
      chk($sformatf("v%0d_cmd_ready_after_done", i), 128'(cmd_ready), 128'(1));
      @(negedge aclk);
    end

    // Reset in the middle of a write burst, then a clean write afterwards
    stall = 0; early = -1; badid = 0; rresp_cfg = 0; bresp_cfg = 0; salt = 64'h55;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_len = 8'd3; cmd_size = 3'd3;
    cmd_id = 4'h3; awready = 1; wready = 1;
    @(negedge aclk);
    cmd_valid = 0;
    #1;
    chk("rw_awvalid", 128'(awvalid), 128'(1));
    @(negedge aclk);
    wr_valid = 1; wr_data = 64'h1; wr_strb = 8'hFF;
    #1;
    chk("rw_wvalid_beat1", 128'(wvalid), 128'(1));
    @(negedge aclk);
    wr_data = 64'h2; areset = 1'b1;
    #1;
    chk("rw_wlast_beat2", 128'(wlast), 128'(0));
    @(negedge aclk);
    #1;
    chk("rw_valids_after_reset", 128'({awvalid, wvalid, arvalid, bready, rready, done_valid, rd_valid}),
        128'(0));
    chk("rw_cmd_ready_in_reset", 128'(cmd_ready), 128'(0));
    areset = 1'b0; wr_valid = 0; awready = 0; wready = 0;
    #1;
    chk("rw_idle_cmd_ready", 128'(cmd_ready), 128'(1));
    @(negedge aclk);
    chk("rw_no_done", 128'(done_valid), 128'(0));
    run_cmd(1, 32'h300, 8'd3, 3'd3, 4'hD, resp, err, nb, bus);
    chk("rw_new_done_resp", 128'(resp), 128'(0));
    chk("rw_new_done_err", 128'(err), 128'(0));
    chk("rw_new_beats", 128'(nb), 128'(4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
